// File: rtl/fir_engine_ctrl.sv
// Control sequencer for an N-tap FIR: clears history, takes one sample per run step,
// walks the tap and data RAMs one MAC per cycle, and hands each result out on AXI-Stream.
module fir_engine_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            XferLength,
    output logic                   reset_ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    input  logic [pADDR_WIDTH-1:0] cfg_tap_A,
    input  logic [3:0]             cfg_tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [3:0]             tap_WE,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    localparam int CW = $clog2(Tape_Num + 1);
    localparam logic [CW-1:0] LAST_K  = CW'(Tape_Num - 1);
    localparam logic [CW-1:0] MAC_END = CW'(Tape_Num);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_IN,
        ST_MAC,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          k_reg, k_next;
    logic [CW-1:0]          wptr_reg, wptr_next;
    logic [31:0]            count_reg, count_next;
    logic [31:0]            len_reg, len_next;
    logic [pDATA_WIDTH-1:0] acc_reg, acc_next;
    logic                   idle_reg, idle_next;

    logic [CW-1:0]          rd_idx;
    logic [pDATA_WIDTH-1:0] product;
    logic [pADDR_WIDTH-1:0] eng_tap_A;
    logic                   unused_inputs;

    // The sample count alone terminates a run, so the stream's tlast is not needed.
    assign unused_inputs = ss_tlast;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] w);
        return pADDR_WIDTH'({w, 2'b00});
    endfunction

    // Circular history index (wptr - k) mod Tape_Num, newest sample first.
    always_comb begin
        if (k_reg <= wptr_reg) begin
            rd_idx = wptr_reg - k_reg;
        end else begin
            rd_idx = wptr_reg + MAC_END - k_reg;
        end
    end

    assign product = pDATA_WIDTH'($signed(tap_Do) * $signed(data_Do));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
            len_reg   <= '0;
            acc_reg   <= '0;
            idle_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            acc_reg   <= acc_next;
            idle_reg  <= idle_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        wptr_next      = wptr_reg;
        count_next     = count_reg;
        len_next       = len_reg;
        acc_next       = acc_reg;
        idle_next      = idle_reg;
        reset_ap_start = 1'b0;
        ap_done        = 1'b0;
        ss_tready      = 1'b0;
        sm_tvalid      = 1'b0;
        sm_tdata       = '0;
        sm_tlast       = 1'b0;
        eng_tap_A      = '0;
        data_WE        = 4'h0;
        data_A         = '0;
        data_Di        = '0;

        unique case (state_reg)
            ST_IDLE: begin
                if (ap_start) begin
                    len_next       = XferLength;
                    count_next     = '0;
                    k_next         = '0;
                    reset_ap_start = 1'b1;
                    idle_next      = 1'b0;
                    state_next     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                data_WE   = 4'hF;
                data_A    = word_addr(k_reg);
                wptr_next = '0;
                if (k_reg == LAST_K) begin
                    k_next     = '0;
                    state_next = (len_reg == 32'd0) ? ST_DONE : ST_WAIT_IN;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            ST_WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_WE    = 4'hF;
                    data_A     = word_addr(wptr_reg);
                    data_Di    = ss_tdata;
                    k_next     = '0;
                    acc_next   = '0;
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                // Address k is issued on cycle k; its product lands one cycle later.
                if (k_reg != MAC_END) begin
                    eng_tap_A = word_addr(k_reg);
                    data_A    = word_addr(rd_idx);
                end
                if (k_reg != '0) begin
                    acc_next = acc_reg + product;
                end
                if (k_reg == MAC_END) begin
                    state_next = ST_OUT;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            ST_OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = acc_reg;
                sm_tlast  = (count_reg == len_reg - 32'd1);
                if (sm_tready) begin
                    count_next = count_reg + 32'd1;
                    wptr_next  = (wptr_reg == LAST_K) ? '0 : wptr_reg + 1'b1;
                    state_next = (count_reg == len_reg - 32'd1) ? ST_DONE : ST_WAIT_IN;
                end
            end
            ST_DONE: begin
                ap_done    = 1'b1;
                idle_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Configuration owns the tap RAM only while idle; busy-time writes are dropped.
    assign tap_A   = (state_reg == ST_IDLE) ? cfg_tap_A : eng_tap_A;
    assign tap_WE  = (state_reg == ST_IDLE) ? cfg_tap_WE : 4'h0;
    assign ap_idle = idle_reg;
    assign data_EN = 1'b1;

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// Bench for fir_engine_ctrl: byte-enabled RAM models, table-driven runs, corner sequences
// and randomized runs checked against a direct convolution model.
`timescale 1ns/1ps
module tb_fir_engine_ctrl;

    localparam int NT = 11;

    logic        clk;
    logic        rst_n;
    logic        ap_start;
    logic [31:0] XferLength;
    logic        reset_ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        sm_tready;
    logic [11:0] cfg_tap_A;
    logic [3:0]  cfg_tap_WE;
    logic [11:0] tap_A;
    logic [3:0]  tap_WE;
    logic [31:0] tap_Do;
    logic [31:0] tap_Di;
    logic        data_EN;
    logic [3:0]  data_WE;
    logic [11:0] data_A;
    logic [31:0] data_Di;
    logic [31:0] data_Do;

    logic [31:0] tap_mem  [0:1023];
    logic [31:0] data_mem [0:1023];

    int passed = 0;
    int total  = 0;
    int h [NT];
    int x_q [$];
    int y_q [$];

    fir_engine_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ap_start       (ap_start),
        .XferLength     (XferLength),
        .reset_ap_start (reset_ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ss_tvalid      (ss_tvalid),
        .ss_tdata       (ss_tdata),
        .ss_tlast       (ss_tlast),
        .ss_tready      (ss_tready),
        .sm_tvalid      (sm_tvalid),
        .sm_tdata       (sm_tdata),
        .sm_tlast       (sm_tlast),
        .sm_tready      (sm_tready),
        .cfg_tap_A      (cfg_tap_A),
        .cfg_tap_WE     (cfg_tap_WE),
        .tap_A          (tap_A),
        .tap_WE         (tap_WE),
        .tap_Do         (tap_Do),
        .data_EN        (data_EN),
        .data_WE        (data_WE),
        .data_A         (data_A),
        .data_Di        (data_Di),
        .data_Do        (data_Do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAMs, registered read, byte write enables.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (tap_WE[b]) tap_mem[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
            if (data_EN && data_WE[b]) data_mem[data_A[11:2]][8*b +: 8] <= data_Di[8*b +: 8];
        end
        tap_Do <= tap_mem[tap_A[11:2]];
        if (data_EN) data_Do <= data_mem[data_A[11:2]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Direct convolution with empty (zero) history before the first sample.
    function automatic void ref_fir();
        y_q.delete();
        for (int n = 0; n < x_q.size(); n++) begin
            int acc = 0;
            for (int k = 0; k < NT; k++) begin
                if (n >= k) acc += h[k] * x_q[n - k];
            end
            y_q.push_back(acc);
        end
    endfunction

    task automatic load_taps();
        for (int i = 0; i < NT; i++) begin
            @(posedge clk); #1;
            cfg_tap_A  = 12'(4 * i);
            cfg_tap_WE = 4'hF;
            tap_Di     = h[i];
            @(negedge clk);
            check("idle_tap_we", tap_WE, 4'hF);
            check("idle_tap_a", tap_A, 12'(4 * i));
        end
        @(posedge clk); #1;
        cfg_tap_WE = 4'h0;
    endtask

    task automatic run_stream(input int len, input int stall_first, input bit rnd);
        int in_idx = 0;
        int out_idx = 0;
        int dones = 0;
        int busy_we_bad = 0;
        int stall_left;
        bit prev_hold = 1'b0;
        bit prev_hs = 1'b0;
        stall_left = stall_first;
        @(posedge clk); #1;
        XferLength = len;
        ap_start   = 1'b1;
        cfg_tap_WE = 4'h0;
        @(negedge clk);
        check("reset_ap_start", reset_ap_start, 1);
        @(posedge clk); #1;
        ap_start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ss_tvalid  = (in_idx < len) && (!rnd || $urandom_range(0, 3) != 0);
            ss_tdata   = ss_tvalid ? x_q[in_idx] : $urandom;
            ss_tlast   = 1'($urandom_range(0, 1));
            sm_tready  = (stall_left > 0) ? 1'b0 : (!rnd || $urandom_range(0, 2) != 0);
            cfg_tap_WE = 4'hF;
            cfg_tap_A  = 12'($urandom_range(0, NT - 1) * 4);
            tap_Di     = $urandom;
            @(negedge clk);
            if (cyc == 0) check("busy_idle", ap_idle, 0);
            if (tap_WE != 4'h0) busy_we_bad++;
            if (prev_hold) check("hold_valid", sm_tvalid, 1);
            if (prev_hs) begin
                check("one_xfer", sm_tvalid, 0);
                if (out_idx == len) check("done_after_last", ap_done, 1);
            end
            if (sm_tvalid) begin
                check("ss_tready_in_out", ss_tready, 0);
                if (out_idx < len) begin
                    check("sm_tdata", sm_tdata, y_q[out_idx]);
                    check("sm_tlast", sm_tlast, (out_idx == len - 1));
                end else begin
                    check("extra_output", sm_tvalid, 0);
                end
            end
            prev_hold = sm_tvalid && !sm_tready;
            prev_hs   = sm_tvalid && sm_tready;
            if (prev_hold && stall_left > 0) stall_left--;
            if (prev_hs) out_idx++;
            if (ss_tvalid && ss_tready) in_idx++;
            if (ap_done) begin
                dones++;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cfg_tap_WE = 4'h0;
        ss_tvalid  = 1'b0;
        sm_tready  = 1'b0;
        @(negedge clk);
        check("done_count", dones, 1);
        check("in_count", in_idx, len);
        check("out_count", out_idx, len);
        check("busy_tap_we", busy_we_bad, 0);
        check("idle_after", ap_idle, 1);
        check("done_pulse", ap_done, 0);
        $display("run len=%0d stall=%0d rnd=%0d: in=%0d out=%0d done=%0d", len, stall_first, rnd,
                 in_idx, out_idx, dones);
    endtask

    typedef struct packed {
        int len;
        int stall;
        int x0, x1, x2, x3;
        int y0, y1, y2, y3;
    } vec_t;

    vec_t tbl [5];
    int   h2 [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    initial begin
        int xa [4];
        int ya [4];
        int edges;
        int traffic;
        int done_seen;

        tbl[0] = '{3, 0, 1, 2, 3, 0, 0, -10, -29, 0};
        tbl[1] = '{3, 5, 1, 2, 3, 0, 0, -10, -29, 0};
        tbl[2] = '{4, 0, 1, 0, 0, 0, 0, -10, -9, 23};
        tbl[3] = '{2, 2, -1, 4, 0, 0, 0, 10, 0, 0};
        tbl[4] = '{1, 0, 5, 0, 0, 0, 0, 0, 0, 0};

        rst_n      = 1'b1;
        ap_start   = 1'b0;
        XferLength = '0;
        ss_tvalid  = 1'b0;
        ss_tdata   = '0;
        ss_tlast   = 1'b0;
        sm_tready  = 1'b0;
        cfg_tap_A  = 12'h028;
        cfg_tap_WE = 4'h5;
        tap_Di     = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ap_idle", ap_idle, 1);
        check("rst_sm_tvalid", sm_tvalid, 0);
        check("rst_ss_tready", ss_tready, 0);
        check("rst_ap_done", ap_done, 0);
        check("rst_reset_ap_start", reset_ap_start, 0);
        check("rst_data_we", data_WE, 0);
        check("rst_sm_tdata", sm_tdata, 0);
        check("rst_tap_we_follow", tap_WE, 4'h5);
        check("rst_tap_a_follow", tap_A, 12'h028);
        @(posedge clk); #1;
        cfg_tap_WE = 4'h0;

        for (int i = 0; i < NT; i++) h[i] = h2[i];
        load_taps();

        for (int v = 0; v < 5; v++) begin
            xa = '{tbl[v].x0, tbl[v].x1, tbl[v].x2, tbl[v].x3};
            ya = '{tbl[v].y0, tbl[v].y1, tbl[v].y2, tbl[v].y3};
            x_q.delete();
            y_q.delete();
            for (int j = 0; j < tbl[v].len; j++) begin
                x_q.push_back(xa[j]);
                y_q.push_back(ya[j]);
            end
            run_stream(tbl[v].len, tbl[v].stall, 1'b0);
        end

        for (int i = 0; i < NT; i++) check("tap_keep", tap_mem[i], h2[i]);

        // Zero-length run: CLEAR only, then DONE.
        @(posedge clk); #1;
        XferLength = 0;
        ap_start   = 1'b1;
        @(negedge clk);
        check("len0_reset_ap_start", reset_ap_start, 1);
        @(posedge clk); #1;
        ap_start  = 1'b0;
        ss_tvalid = 1'b1;
        ss_tdata  = 32'd99;
        sm_tready = 1'b1;
        edges     = 0;
        traffic   = 0;
        done_seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ss_tready || sm_tvalid) traffic++;
            if (ap_done) begin
                done_seen = 1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        check("len0_done", done_seen, 1);
        check("len0_clear_cycles", edges, NT);
        check("len0_traffic", traffic, 0);
        @(posedge clk); #1;
        ss_tvalid = 1'b0;
        sm_tready = 1'b0;
        @(negedge clk);
        check("len0_idle", ap_idle, 1);
        $display("len0 run: clear_cycles=%0d traffic=%0d", edges, traffic);

        // Reset in the middle of MAC.
        cfg_tap_A = 12'h010;
        @(posedge clk); #1;
        XferLength = 3;
        ap_start   = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        ap_start  = 1'b0;
        ss_tvalid = 1'b1;
        ss_tdata  = 32'd7;
        done_seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ss_tready) begin
                done_seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("mac_sample_taken", done_seen, 1);
        @(posedge clk); #1;
        ss_tvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_idle", ap_idle, 1);
        check("midrst_ss_tready", ss_tready, 0);
        check("midrst_sm_tvalid", sm_tvalid, 0);
        check("midrst_tap_a", tap_A, 12'h010);
        done_seen = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ap_done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_idle_after", ap_idle, 1);
        $display("mid-MAC reset: ap_done pulses after reset=%0d", done_seen);
        x_q = '{5};
        y_q = '{0};
        run_stream(1, 0, 1'b0);

        // Randomized runs against the convolution model.
        for (int r = 0; r < 6; r++) begin
            int len;
            for (int i = 0; i < NT; i++) begin
                h[i] = (r % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            end
            load_taps();
            len = $urandom_range(1, 25);
            x_q.delete();
            for (int j = 0; j < len; j++) begin
                x_q.push_back((r % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000);
            end
            ref_fir();
            run_stream(len, $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
